// File: rtl/usb4_cfg_pkg.sv
// Shared definitions for the logical layer's configuration-space access bus.
// Holds the bus widths, the arbiter state encoding and the latched request payload.
package usb4_cfg_pkg;

    localparam int unsigned CFG_ADDR_W = 8;
    localparam int unsigned CFG_DATA_W = 32;
    // Read-latency counter width; covers RD_LAT-1 for RD_LAT up to 7.
    localparam int unsigned CFG_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } cfg_arb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] wdata;
    } cfg_req_t;

endpackage

// File: rtl/cfg_rr_pick.sv
// Combinational 2-way round-robin picker.
// Ports:
//   req[1:0]    pending requests
//   last_grant  index of the most recent winner
//   valid       at least one request pending
//   grant_idx   index of the winner (meaningful only when valid)
module cfg_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant_idx
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        valid     = |req;
        grant_idx = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/config_space_arbiter.sv
// Two-port arbiter/sequencer for the single config-space access bus.
// Requester 0 is the sideband register engine, requester 1 the lane-training FSM.
// One access at a time: grant, one-cycle strobe, fixed read latency, one-cycle ack.
// Ports:
//   local_clk, rst                     clock, asynchronous active-high reset
//   req_i/req_wr_i/req_addr_i/req_wdata_i  per-requester request (level) and payload
//   ack_o                              one-cycle completion pulse per requester
//   rdata_o                            read data, valid with ack_o for a read
//   busy_o                             transaction in flight
//   c_read/c_write/c_address/c_data_in config-space strobes, address and write data
//   c_data_out                         config-space read data, RD_LAT cycles after c_read
// ADDR_W/DATA_W must not exceed the package widths; RD_LAT legal range is 1..7.
module config_space_arbiter
    import usb4_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W = CFG_ADDR_W,
    parameter int unsigned DATA_W = CFG_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   local_clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0]             req_wr_i,
    input  logic [1:0][ADDR_W-1:0] req_addr_i,
    input  logic [1:0][DATA_W-1:0] req_wdata_i,
    output logic [1:0]             ack_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   busy_o,
    output logic                   c_read,
    output logic                   c_write,
    output logic [ADDR_W-1:0]      c_address,
    output logic [DATA_W-1:0]      c_data_in,
    input  logic [DATA_W-1:0]      c_data_out
);

    cfg_arb_state_e        state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    cfg_req_t              lat_q, lat_d;
    logic [CFG_CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]            ack_d;
    logic [DATA_W-1:0]     rdata_d;
    logic                  c_read_d, c_write_d;
    logic                  pick_valid;
    logic                  pick_idx;

    // Winner selection among pending requests.
    cfg_rr_pick u_pick (
        .req        (req_i),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .grant_idx  (pick_idx)
    );

    // Address and write data come straight from the request latch, so they
    // change only at a grant and otherwise hold their last values.
    assign c_address = ADDR_W'(lat_q.addr);
    assign c_data_in = DATA_W'(lat_q.wdata);

    // Next-state and next-output logic. Strobes and ack are computed one state
    // early so that they are registered and line up with ISSUE/ACK.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lat_d        = lat_q;
        cnt_d        = cnt_q;
        ack_d        = 2'b00;
        rdata_d      = rdata_o;
        c_read_d     = 1'b0;
        c_write_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = ISSUE;
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    lat_d.wr     = req_wr_i[pick_idx];
                    lat_d.addr   = CFG_ADDR_W'(req_addr_i[pick_idx]);
                    lat_d.wdata  = CFG_DATA_W'(req_wdata_i[pick_idx]);
                    c_write_d    = req_wr_i[pick_idx];
                    c_read_d     = ~req_wr_i[pick_idx];
                end
            end
            ISSUE: begin
                if (lat_q.wr) begin
                    state_d = ACK;
                    ack_d   = 2'b01 << grant_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CFG_CNT_W'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    rdata_d = c_data_out;
                    ack_d   = 2'b01 << grant_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lat_q        <= '0;
            cnt_q        <= '0;
            ack_o        <= 2'b00;
            rdata_o      <= '0;
            busy_o       <= 1'b0;
            c_read       <= 1'b0;
            c_write      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lat_q        <= lat_d;
            cnt_q        <= cnt_d;
            ack_o        <= ack_d;
            rdata_o      <= rdata_d;
            busy_o       <= (state_d != IDLE);
            c_read       <= c_read_d;
            c_write      <= c_write_d;
        end
    end

endmodule

// File: tb/tb_config_space_arbiter.sv
// Scoreboard bench for config_space_arbiter, one instance per read latency (1 and 3).
`timescale 1ns/1ps
module tb_config_space_arbiter;

    localparam int unsigned NINST  = 2;
    localparam int unsigned N_DUAL = 8;
    localparam int unsigned N_RAND = 12;

    typedef struct {
        int          who;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int lat, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (rd_lat=%0d): got 0x%0h, expected 0x%0h", name, lat, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input int lat);
        checks++;
        errors++;
        $display("FAIL %s (rd_lat=%0d): event seen, none expected", name, lat);
    endtask

    // Power-up contents of the config space; 0x40 holds a known pattern.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h40) return 32'hA5A5_0001;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
        localparam int unsigned LAT = (gi == 0) ? 1 : 3;

        logic        rst = 1'b1;
        logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
        logic [7:0]  addr0 = '0, addr1 = '0;
        logic [31:0] wd0 = '0, wd1 = '0;
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic        busy, c_read, c_write;
        logic [7:0]  c_address;
        logic [31:0] c_data_in, c_data_out;
        bit          done = 1'b0;
        int          cyc = 0;
        exp_t        exp_q [$];
        bit [31:0]   ref_mem [256];
        bit          ref_wr  [256];
        bit [31:0]   env_mem [256];
        bit          env_wr  [256];
        bit [31:0]   pipe [LAT];
        bit          pv   [LAT];

        config_space_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(LAT)) u_dut (
            .local_clk   (clk),
            .rst         (rst),
            .req_i       ({req1, req0}),
            .req_wr_i    ({wr1, wr0}),
            .req_addr_i  ({addr1, addr0}),
            .req_wdata_i ({wd1, wd0}),
            .ack_o       (ack),
            .rdata_o     (rdata),
            .busy_o      (busy),
            .c_read      (c_read),
            .c_write     (c_write),
            .c_address   (c_address),
            .c_data_in   (c_data_in),
            .c_data_out  (c_data_out)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Config-space register file: data appears LAT cycles after the read strobe.
        always @(posedge clk) begin
            if (c_write) begin
                env_mem[c_address] <= c_data_in;
                env_wr[c_address]  <= 1'b1;
            end
            pv[0]   <= c_read;
            pipe[0] <= env_wr[c_address] ? env_mem[c_address] : init_val(c_address);
            for (int i = 1; i < LAT; i++) begin
                pv[i]   <= pv[i-1];
                pipe[i] <= pipe[i-1];
            end
        end
        assign c_data_out = pv[LAT-1] ? pipe[LAT-1] : (32'hBAD0_0000 | 32'(cyc[15:0]));

        // Reference model: accesses are serialised, so each one sees all earlier writes.
        task automatic push_exp(input int who, input bit wr, input logic [7:0] a,
                                input logic [31:0] d, input bit abort);
            exp_t e;
            e.who = who; e.wr = wr; e.addr = a; e.wdata = d; e.abort = abort;
            e.rdata = ref_wr[a] ? ref_mem[a] : init_val(a);
            if (wr && !abort) begin
                ref_mem[a] = d;
                ref_wr[a]  = 1'b1;
            end
            exp_q.push_back(e);
        endtask

        task automatic drive(input int who, input bit v, input bit wr, input logic [7:0] a, input logic [31:0] d);
            if (who == 0) begin req0 = v; wr0 = wr; addr0 = a; wd0 = d; end
            else          begin req1 = v; wr1 = wr; addr1 = a; wd1 = d; end
        endtask

        task automatic wait_ack(input int who);
            bit ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (ack[who]) begin ok = 1'b1; break; end
            end
            if (!ok) report_fail("ack_timeout", LAT);
            @(posedge clk); #1;
        endtask

        task automatic wait_strobe();
            bit ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (c_read || c_write) begin ok = 1'b1; break; end
            end
            if (!ok) report_fail("strobe_timeout", LAT);
        endtask

        task automatic access(input int who, input bit wr, input logic [7:0] a, input logic [31:0] d, input bit keep);
            drive(who, 1'b1, wr, a, d);
            wait_ack(who);
            if (!keep) drive(who, 1'b0, wr, a, d);
        endtask

        task automatic check_quiet(input string tag);
            check({tag, "_ack"},     LAT, 64'(ack),       64'd0);
            check({tag, "_busy"},    LAT, 64'(busy),      64'd0);
            check({tag, "_c_read"},  LAT, 64'(c_read),    64'd0);
            check({tag, "_c_write"}, LAT, 64'(c_write),   64'd0);
            check({tag, "_c_addr"},  LAT, 64'(c_address), 64'd0);
            check({tag, "_c_din"},   LAT, 64'(c_data_in), 64'd0);
            check({tag, "_rdata"},   LAT, 64'(rdata),     64'd0);
        endtask

        // Monitor: checks every strobe and ack against the head of the queue.
        initial begin
            bit   struck;
            int   scyc;
            exp_t e;
            struck = 1'b0;
            scyc   = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    if (struck && exp_q.size() > 0 && exp_q[0].abort) void'(exp_q.pop_front());
                    struck = 1'b0;
                end else begin
                    if (c_read && c_write) report_fail("dual_strobe", LAT);
                    if (c_read || c_write) begin
                        if (struck || exp_q.size() == 0) report_fail("unexpected_strobe", LAT);
                        else begin
                            e = exp_q[0];
                            check("strobe_kind", LAT, 64'({c_write, c_read}), e.wr ? 64'd2 : 64'd1);
                            check("c_address", LAT, 64'(c_address), 64'(e.addr));
                            if (e.wr) check("c_data_in", LAT, 64'(c_data_in), 64'(e.wdata));
                            check("busy_at_strobe", LAT, 64'(busy), 64'd1);
                            struck = 1'b1;
                            scyc   = cyc;
                        end
                    end
                    if (ack != 2'b00) begin
                        if (!struck || exp_q.size() == 0) report_fail("unexpected_ack", LAT);
                        else begin
                            e = exp_q.pop_front();
                            if (e.abort) report_fail("ack_after_abort", LAT);
                            check("ack_bits", LAT, 64'(ack), (e.who == 0) ? 64'd1 : 64'd2);
                            if (!e.wr) check("rdata", LAT, 64'(rdata), 64'(e.rdata));
                            check("ack_latency", LAT, 64'(cyc - scyc), e.wr ? 64'd1 : 64'(LAT + 1));
                            struck = 1'b0;
                        end
                    end
                end
            end
        end

        // Stimulus
        initial begin
            int          who;
            bit          wr;
            logic [7:0]  a;
            logic [31:0] d;
            bit          dwr [2][N_DUAL];
            logic [7:0]  dad [2][N_DUAL];
            logic [31:0] ddt [2][N_DUAL];

            repeat (3) @(posedge clk);
            #1;
            check_quiet("in_reset");
            rst = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check_quiet("after_release");

            // Single write from requester 0, single read from requester 1.
            push_exp(0, 1'b1, 8'h12, 32'hDEAD_BEEF, 1'b0);
            access(0, 1'b1, 8'h12, 32'hDEAD_BEEF, 1'b0);
            push_exp(1, 1'b0, 8'h40, 32'h0, 1'b0);
            access(1, 1'b0, 8'h40, 32'h0, 1'b0);

            // Requester 0 withdraws during the issue cycle; access still completes once.
            d = $urandom;
            push_exp(0, 1'b1, 8'h33, d, 1'b0);
            drive(0, 1'b1, 1'b1, 8'h33, d);
            wait_strobe();
            drive(0, 1'b0, 1'b1, 8'h33, d);
            wait_ack(0);
            repeat (10) @(posedge clk);
            #1;

            // Random single-requester traffic over a small address window.
            for (int k = 0; k < int'(N_RAND); k++) begin
                who = int'($urandom_range(0, 1));
                wr  = 1'($urandom_range(0, 1));
                a   = 8'($urandom_range(8'h10, 8'h3F));
                d   = $urandom;
                push_exp(who, wr, a, d, 1'b0);
                access(who, wr, a, d, 1'b0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end

            // Continuous dual requests after reset: grants alternate starting with 0.
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < int'(N_DUAL); k++) begin
                for (int r = 0; r < 2; r++) begin
                    dwr[r][k] = 1'($urandom_range(0, 1));
                    dad[r][k] = 8'($urandom_range(8'h10, 8'h1F));
                    ddt[r][k] = $urandom;
                end
                for (int r = 0; r < 2; r++) push_exp(r, dwr[r][k], dad[r][k], ddt[r][k], 1'b0);
            end
            fork
                begin
                    for (int k = 0; k < int'(N_DUAL); k++)
                        access(0, dwr[0][k], dad[0][k], ddt[0][k], k != int'(N_DUAL) - 1);
                end
                begin
                    for (int k = 0; k < int'(N_DUAL); k++)
                        access(1, dwr[1][k], dad[1][k], ddt[1][k], k != int'(N_DUAL) - 1);
                end
            join
            repeat (4) @(posedge clk);
            #1;

            // Reset during the read wait: no ack, then a normal grant afterwards.
            push_exp(1, 1'b0, 8'h40, 32'h0, 1'b1);
            drive(1, 1'b1, 1'b0, 8'h40, 32'h0);
            wait_strobe();
            @(posedge clk); #1;
            check("busy_in_wait", LAT, 64'(busy), 64'd1);
            rst = 1'b1;
            #1;
            check("abort_c_read", LAT, 64'(c_read), 64'd0);
            check("abort_ack",    LAT, 64'(ack),    64'd0);
            check("abort_busy",   LAT, 64'(busy),   64'd0);
            drive(1, 1'b0, 1'b0, 8'h40, 32'h0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            check("abort_dropped", LAT, 64'(exp_q.size()), 64'd0);
            push_exp(1, 1'b0, 8'h40, 32'h0, 1'b0);
            access(1, 1'b0, 8'h40, 32'h0, 1'b0);

            repeat (5) @(posedge clk);
            #1;
            check("queue_empty", LAT, 64'(exp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            if (g_inst[0].done && g_inst[1].done) break;
            @(posedge clk);
        end
        if (!(g_inst[0].done && g_inst[1].done)) report_fail("global_timeout", 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_space_arbiter.md
# config_space_arbiter

Two-port arbiter and sequencer that shares the logical layer's single configuration-space access bus (`c_read`/`c_write`/`c_address`/`c_data_in`/`c_data_out`). Requester 0 is the sideband register-access engine and requester 1 is the lane-training/adapter FSM. The arbiter grants one requester at a time with round-robin priority, issues exactly one single-cycle read or write strobe, waits the fixed read latency, and returns read data with a one-cycle acknowledge. It sits between those requesters and the config-space register file, inside `logical_layer`, on the `local_clk` domain.

## Interface
Parameters:
- `ADDR_W`, 8: config-space address width.
- `DATA_W`, 32: config-space data width.
- `RD_LAT`, 1: cycles from `c_read` strobe to valid `c_data_out`. Legal range is 1..7.

Ports:
- `local_clk`  in  1  block clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_i[1:0]`  in  2  access request per requester; level signal.
- `req_wr_i[1:0]`  in  2  per requester: 1 = write, 0 = read.
- `req_addr_i[1:0]`  in  2×ADDR_W  per-requester address.
- `req_wdata_i[1:0]`  in  2×DATA_W  per-requester write data.
- `ack_o[1:0]`  out  2  one-cycle completion pulse per requester.
- `rdata_o`  out  DATA_W  read data; valid only while an `ack_o` bit is high for a read.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `c_read`  out  1  config-space read strobe.
- `c_write`  out  1  config-space write strobe.
- `c_address`  out  ADDR_W  config-space address.
- `c_data_in`  out  DATA_W  config-space write data.
- `c_data_out`  in  DATA_W  config-space read data.

## Operation
- FSM states are IDLE, ISSUE, WAIT, ACK.
- **IDLE:**
  - If any `req_i` bit is set, pick the winner and latch its index, wr, addr and wdata. Go to ISSUE.
  - With one request pending, that requester wins.
  - With both pending, the requester not in `last_grant` wins.
  - `last_grant` is updated at the grant.
- **ISSUE (1 cycle):**
  - Drive `c_address` and `c_data_in` from the latched values.
  - Assert `c_write` for a write or `c_read` for a read.
  - Write: go to ACK. Read: load the latency counter with `RD_LAT`-1 and go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter is 0, register `c_data_out` into `rdata_o` and go to ACK.
- **ACK (1 cycle):** assert `ack_o[grant]`, then return to IDLE.
- Latched request fields are held from the grant until ACK. Requester inputs are ignored after the grant.
- Requesters must hold `req`, `wr`, `addr` and `wdata` stable until they see `ack`, and must drop `req` in the cycle after `ack` unless they have a new access.
- If `req` drops after the grant, the transaction still completes and `ack` still pulses.
- Outside ISSUE, `c_read` and `c_write` are 0 and `c_address`/`c_data_in` hold their last values.
- `rdata_o` holds its value until the next read capture.

## Timing
- Reset values: state IDLE, `last_grant` = 1 (requester 0 wins the first tie). All of these are 0: `ack_o`, `busy_o`, `c_read`, `c_write`, `c_address`, `c_data_in`, `rdata_o`, counter.
- `rst` asserted mid-transaction aborts it immediately. No `ack` is produced, and any strobe drops asynchronously.
- Write latency, with request seen in IDLE at cycle T: `c_write` at T+1, `ack` at T+2.
- Read latency: `c_read` at T+1, data sampled at T+1+`RD_LAT`, `ack`/`rdata_o` valid at T+2+`RD_LAT`.
- Back-to-back: the next IDLE arbitration happens the cycle after ACK. Minimum spacing between strobes is 3 cycles for writes and 3+`RD_LAT` cycles for reads.
- Under continuous dual requests, grants strictly alternate 0,1,0,1.
- All outputs are registered; there is no combinational path from `req_i` to `c_*`.

## Structure
- Shared package `usb4_cfg_pkg` holds:
  - `CFG_ADDR_W` and `CFG_DATA_W` constants.
  - The `cfg_arb_state_e` enum {IDLE, ISSUE, WAIT, ACK}.
  - The `cfg_req_t` struct {wr, addr, wdata}.
- One sub-module, `cfg_rr_pick`: a combinational 2-way round-robin picker. Inputs are `req[1:0]` and `last_grant`; outputs are `valid` and `grant_idx`.
- The FSM, counter and latches stay in the top.

## Test plan
- **Reset values:** hold `rst`=1 → all outputs 0 and `busy_o`=0; release with no requests → nothing changes.
- **Single write:** req 0 writes addr 0x12, data 0xDEADBEEF.
  - Expect `c_write` high exactly 1 cycle, with `c_address`=0x12 and `c_data_in`=0xDEADBEEF.
  - Expect `ack_o`=2'b01 one cycle later.
- **Single read, `RD_LAT`=1 and `RD_LAT`=3:** req 1 reads 0x40 while the model returns 0xA5A5_0001.
  - Expect `c_read` for 1 cycle.
  - Expect `ack_o`=2'b10 with `rdata_o`=0xA5A5_0001 exactly `RD_LAT`+1 cycles after the strobe.
- **Simultaneous requests:** both requesters assert requests continuously after reset → grant order 0,1,0,1. Never two strobes in one cycle, and exactly one `ack` bit per transaction.
- **Request withdrawn:** req 0 drops one cycle after the grant → the transaction still completes with `ack_o`[0] pulsing once, and there is no second access.
- **Reset mid-read (`RD_LAT`=3):** assert `rst` during WAIT → `c_read`, `ack_o` and `busy_o` go to 0 at once, with no `ack` after release. After release, req 1 with req 0 idle → granted normally.
